// File: rtl/dffrsnq_bank_driver.sv
// Sequences set / clear / load / check operations on a bank of set-reset flops
// and returns the Q readback together with a compare against the expected value.
module dffrsnq_bank_driver #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned PULSE_CYC  = 2,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             SETN_o,
   output logic             RN_o,
   output logic [WIDTH-1:0] D_o,
   output logic             CKE,
   input  logic [WIDTH-1:0] Q_i,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_pass,
   output logic [WIDTH-1:0] rsp_q,
   output logic [15:0]      err_cnt
);

   localparam int unsigned CNT_MAX   = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned ERR_W     = 16;
   localparam int unsigned PULSE_LD  = (PULSE_CYC > 0) ? PULSE_CYC - 1 : 0;
   localparam int unsigned SETTLE_LD = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_SET   = 2'd1;
   localparam logic [1:0] OP_CLR   = 2'd2;
   localparam logic [1:0] OP_CHECK = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      ASSERT,
      RELEASE,
      SETUP,
      CLOCK,
      SAMPLE,
      RESP
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         op_q, op_nxt;
   logic [WIDTH-1:0]   exp_q, exp_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               setn_nxt, rn_nxt, cke_nxt;
   logic [WIDTH-1:0]   d_nxt;
   logic               rsp_valid_nxt, rsp_pass_nxt;
   logic [WIDTH-1:0]   rsp_q_nxt;
   logic [ERR_W-1:0]   err_nxt;

   assign cmd_ready = (state == IDLE);

   // State register and registered bank / response outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         op_q      <= OP_LOAD;
         exp_q     <= '0;
         cnt       <= '0;
         SETN_o    <= 1'b1;
         RN_o      <= 1'b1;
         D_o       <= '0;
         CKE       <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_pass  <= 1'b0;
         rsp_q     <= '0;
         err_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         op_q      <= op_nxt;
         exp_q     <= exp_nxt;
         cnt       <= cnt_nxt;
         SETN_o    <= setn_nxt;
         RN_o      <= rn_nxt;
         D_o       <= d_nxt;
         CKE       <= cke_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_pass  <= rsp_pass_nxt;
         rsp_q     <= rsp_q_nxt;
         err_cnt   <= err_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      op_nxt        = op_q;
      exp_nxt       = exp_q;
      cnt_nxt       = cnt;
      d_nxt         = D_o;
      rsp_valid_nxt = rsp_valid;
      rsp_pass_nxt  = rsp_pass;
      rsp_q_nxt     = rsp_q;
      err_nxt       = err_cnt;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               op_nxt = cmd_op;
               case (cmd_op)
                  OP_SET: begin
                     exp_nxt   = '1;
                     cnt_nxt   = CNT_W'(PULSE_LD);
                     state_nxt = ASSERT;
                  end
                  OP_CLR: begin
                     exp_nxt   = '0;
                     cnt_nxt   = CNT_W'(PULSE_LD);
                     state_nxt = ASSERT;
                  end
                  OP_LOAD: begin
                     exp_nxt   = cmd_data;
                     d_nxt     = cmd_data;
                     state_nxt = SETUP;
                  end
                  default: begin
                     exp_nxt   = cmd_data;
                     state_nxt = SAMPLE;
                  end
               endcase
            end
         end
         ASSERT: begin
            if (cnt == '0) begin
               if (SETTLE_CYC == 0) begin
                  state_nxt = SAMPLE;
               end else begin
                  cnt_nxt   = CNT_W'(SETTLE_LD);
                  state_nxt = RELEASE;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         RELEASE: begin
            if (cnt == '0) begin
               state_nxt = SAMPLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         SETUP: begin
            state_nxt = CLOCK;
         end
         CLOCK: begin
            if (SETTLE_CYC == 0) begin
               state_nxt = SAMPLE;
            end else begin
               cnt_nxt   = CNT_W'(SETTLE_LD);
               state_nxt = RELEASE;
            end
         end
         SAMPLE: begin
            rsp_q_nxt     = Q_i;
            rsp_pass_nxt  = (Q_i == exp_q);
            rsp_valid_nxt = 1'b1;
            if ((Q_i != exp_q) && (err_cnt != '1)) begin
               err_nxt = err_cnt + ERR_W'(1);
            end
            state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Pins follow the state being entered so they are valid for its whole duration
      setn_nxt = !((state_nxt == ASSERT) && (op_nxt == OP_SET));
      rn_nxt   = !((state_nxt == ASSERT) && (op_nxt == OP_CLR));
      cke_nxt  = (state_nxt == CLOCK);
   end

endmodule

// File: tb/tb_dffrsnq_bank_driver.sv
// Randomized scoreboard bench for dffrsnq_bank_driver with a cycle model of the flop bank
// and a command-level reference model of the expected responses.
module tb_dffrsnq_bank_driver;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned PULSE_CYC  = 2;
   localparam int unsigned SETTLE_CYC = 1;

   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_SET   = 2'd1;
   localparam logic [1:0] OP_CLR   = 2'd2;
   localparam logic [1:0] OP_CHECK = 2'd3;

   logic             CLK = 1'b0;
   logic             RST;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             SETN_o;
   logic             RN_o;
   logic [WIDTH-1:0] D_o;
   logic             CKE;
   logic [WIDTH-1:0] Q_i;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_pass;
   logic [WIDTH-1:0] rsp_q;
   logic [15:0]      err_cnt;

   dffrsnq_bank_driver #(
      .WIDTH      (WIDTH),
      .PULSE_CYC  (PULSE_CYC),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .SETN_o    (SETN_o),
      .RN_o      (RN_o),
      .D_o       (D_o),
      .CKE       (CKE),
      .Q_i       (Q_i),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_pass  (rsp_pass),
      .rsp_q     (rsp_q),
      .err_cnt   (err_cnt)
   );

   always #5 CLK = ~CLK;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Flop bank: set dominates reset, otherwise load on a gated clock
   logic [WIDTH-1:0] bank_q    = '0;
   logic             stuck     = 1'b0;
   logic [WIDTH-1:0] stuck_val = '0;

   always @(posedge CLK) begin
      if (!SETN_o)     bank_q <= '1;
      else if (!RN_o)  bank_q <= '0;
      else if (CKE)    bank_q <= D_o;
   end

   assign Q_i = stuck ? stuck_val : bank_q;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             pass;
      logic [15:0]      err;
      int unsigned      acc;
      int unsigned      lat;
   } exp_t;

   exp_t             sb[$];
   logic [WIDTH-1:0] ref_bank = '0;
   logic [15:0]      ref_err  = '0;
   logic [WIDTH-1:0] ld_data  = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Issue one command; the reference model predicts the response at the command level
   task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data,
                        input logic stk, input logic [WIDTH-1:0] sv);
      exp_t             e;
      logic [WIDTH-1:0] expv;
      int               n;
      n = 0;
      @(negedge CLK);
      while (!cmd_ready && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
         return;
      end
      stuck     = stk;
      stuck_val = sv;
      case (op)
         OP_SET:  begin ref_bank = '1;   expv = '1;   e.lat = PULSE_CYC + SETTLE_CYC + 1; end
         OP_CLR:  begin ref_bank = '0;   expv = '0;   e.lat = PULSE_CYC + SETTLE_CYC + 1; end
         OP_LOAD: begin ref_bank = data; expv = data; e.lat = SETTLE_CYC + 3; ld_data = data; end
         default: begin                  expv = data; e.lat = 1; end
      endcase
      e.q    = stk ? sv : ref_bank;
      e.pass = (e.q == expv);
      if (!e.pass && ref_err != 16'hFFFF) ref_err = ref_err + 16'd1;
      e.err     = ref_err;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge CLK);
      #1;
      e.acc = cyc;
      sb.push_back(e);
      cmd_valid = 1'b0;
      cmd_op    = OP_LOAD;
      cmd_data  = '0;
   endtask

   // Wait until every issued command has produced and retired its response
   task automatic drain(input logic rand_ready);
      int n;
      n = 0;
      while ((sb.size() != 0 || rsp_valid) && n < 300) begin
         @(negedge CLK);
         if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
         n++;
      end
      if (sb.size() != 0 || rsp_valid) chk("drain_timeout", 32'(sb.size()), 32'd0);
      rsp_ready = 1'b1;
   endtask

   // Response monitor plus pin-level protocol checks
   logic             prev_valid = 1'b0;
   logic             prev_cke   = 1'b0;
   logic [WIDTH-1:0] prev_d     = '0;
   int unsigned      setn_run   = 0;
   int unsigned      rn_run     = 0;

   always @(negedge CLK) begin
      exp_t e;
      checks++;
      assert (SETN_o || RN_o) else begin
         errors++;
         $display("FAIL both_low SETN_o=%0b RN_o=%0b exp=not both 0", SETN_o, RN_o);
      end
      if (CKE) begin
         chk("cke_while_async", 32'({SETN_o, RN_o}), 32'h3);
         chk("cke_single", 32'(prev_cke), 32'd0);
         chk("d_at_cke", 32'(D_o), 32'(ld_data));
         chk("d_before_cke", 32'(prev_d), 32'(ld_data));
      end
      if (!SETN_o) setn_run++;
      else if (setn_run != 0) begin
         chk("setn_width", setn_run, PULSE_CYC);
         setn_run = 0;
      end
      if (!RN_o) rn_run++;
      else if (rn_run != 0) begin
         chk("rn_width", rn_run, PULSE_CYC);
         rn_run = 0;
      end
      if (rsp_valid && !prev_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_q", 32'(rsp_q), 32'(e.q));
            chk("rsp_pass", 32'(rsp_pass), 32'(e.pass));
            chk("err_cnt", 32'(err_cnt), 32'(e.err));
            chk("latency", cyc - e.acc, e.lat);
         end
      end
      prev_valid = rsp_valid;
      prev_cke   = CKE;
      prev_d     = D_o;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [1:0]       op;
      logic [WIDTH-1:0] data;
      RST       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_LOAD;
      cmd_data  = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_setn", 32'(SETN_o), 32'd1);
      chk("rst_rn", 32'(RN_o), 32'd1);
      chk("rst_d", 32'(D_o), 32'd0);
      chk("rst_cke", 32'(CKE), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_pass", 32'(rsp_pass), 32'd0);
      chk("rst_rsp_q", 32'(rsp_q), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

      // Directed: set, load, stuck-bit check
      issue(OP_SET, 8'h00, 1'b0, 8'h00);
      drain(1'b0);
      issue(OP_LOAD, 8'hA5, 1'b0, 8'h00);
      drain(1'b0);
      issue(OP_CHECK, 8'h3C, 1'b1, 8'h3D);
      drain(1'b0);

      // Response held off by rsp_ready
      rsp_ready = 1'b0;
      issue(OP_CHECK, 8'hA5, 1'b0, 8'h00);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("hold_valid_rise", 32'(rsp_valid), 32'd1);
      repeat (5) begin
         @(negedge CLK);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_q", 32'(rsp_q), 32'hA5);
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("release_valid", 32'(rsp_valid), 32'd0);

      // Reset during the second cycle of a clear pulse
      issue(OP_CLR, 8'h00, 1'b0, 8'h00);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      sb.delete();
      ref_err  = '0;
      ref_bank = '0;
      ld_data  = '0;
      chk("abort_rn", 32'(RN_o), 32'd1);
      chk("abort_setn", 32'(SETN_o), 32'd1);
      chk("abort_cke", 32'(CKE), 32'd0);
      chk("abort_err", 32'(err_cnt), 32'd0);
      chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (8) begin
         @(negedge CLK);
         chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Randomized traffic with random back-pressure and occasional stuck readback
      for (int i = 0; i < 150; i++) begin
         op   = 2'($urandom_range(0, 3));
         data = WIDTH'($urandom);
         if (op == OP_CHECK && $urandom_range(0, 1) == 1) data = ref_bank;
         issue(op, data, ($urandom_range(0, 7) == 0), WIDTH'($urandom));
         drain(1'b1);
      end

      // Saturation of the error counter
      stuck = 1'b0;
      @(negedge CLK);
      force dut.err_cnt = 16'hFFFC;
      @(negedge CLK);
      release dut.err_cnt;
      ref_err = 16'hFFFC;
      chk("preload_err", 32'(err_cnt), 32'hFFFC);
      for (int i = 0; i < 6; i++) begin
         issue(OP_CHECK, 8'h00, 1'b1, 8'h01);
         drain(1'b0);
      end
      issue(OP_CHECK, 8'h5A, 1'b1, 8'h5A);
      drain(1'b0);
      @(negedge CLK);
      chk("err_saturated", 32'(err_cnt), 32'hFFFF);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      repeat (3) @(posedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
